seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, handshaked successor to the single-cycle ALU: same 4-bit `ctr` operation encoding, now with every operation implemented, registered results, and iterative shifting that trades latency for area. Sits between the NPC decode/operand stage and writeback, and is driven by a valid/ready pair on each side. It also reports zero and less flags for branch resolution.

## Interface
- `WIDTH`, 32, operand/result width; power of two, ≥ 8.
- `SH_STEP`, 1, bit positions shifted per cycle; power of two, 1..WIDTH.
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — asynchronous, active-high reset.
- `in_valid` in 1 — operands and `ctr` valid.
- `in_ready` out 1 — block can accept an operation.
- `A` in WIDTH — operand A.
- `B` in WIDTH — operand B; the shift amount is `B[$clog2(WIDTH)-1:0]`.
- `ctr` in 4 — operation select.
- `out_valid` out 1 — result valid.
- `out_ready` in 1 — consumer accepts the result.
- `out` out WIDTH — registered result.
- `zero` out 1 — `out == 0`, registered with `out`.
- `less` out 1 — signed or unsigned less-than flag, set by the compare ops and forced to 0 by all other ops.

## Operation
- `ctr[2:0]` operation table; `ctr[3]` selects the variant where marked:
  - 000: add (`ctr[3]=0`) or subtract (`ctr[3]=1`).
  - 001: shift left.
  - 010: signed set-less-than (`ctr[3]=0`) or unsigned set-less-than (`ctr[3]=1`).
  - 011: pass B.
  - 100: xor.
  - 101: logical right shift (`ctr[3]=0`) or arithmetic right shift (`ctr[3]=1`).
  - 110: or.
  - 111: and.
- Arithmetic wraps modulo 2^WIDTH.
- Set-less-than produces the 1-bit result zero-extended to WIDTH, and copies it to `less`.
- State machine states: IDLE, SHIFT, DONE.
  - IDLE: `in_ready`=1. On `in_valid`, latch A, B and `ctr`.
    - Non-shift op, or shift with shamt=0: compute the result and go to DONE.
    - Shift with shamt≠0: load the working register with A and the remaining count with shamt, then go to SHIFT.
  - SHIFT: each cycle, shift by min(SH_STEP, remaining) and decrement remaining by the same amount. Go to DONE in the cycle remaining reaches 0.
  - DONE: `out_valid`=1. `out`, `zero` and `less` are held stable until `out_ready`, then return to IDLE.
- `in_ready` is 0 in SHIFT and DONE; there is no pass-through.
- Arithmetic right shift fills vacated bits with the latched A[WIDTH-1].

## Timing
- Reset state: IDLE, `in_ready`=1, `out_valid`=0, `out`=0, `zero`=0, `less`=0.
- Asserting `rst` mid-operation aborts the operation; no result is produced.
- Latency, counted in edges from the accepting edge to `out_valid` high:
  - Non-shift ops, and shifts with shamt=0: 1.
  - Shifts with shamt n>0: 1+ceil(n/SH_STEP).
- Peak throughput is one operation per 2 cycles (IDLE→DONE→IDLE).
- `in_valid` while `in_ready`=0 is ignored, not queued.
- Under back-pressure (`out_ready`=0), the block stays in DONE indefinitely with the result unchanged.
- A second operation is accepted no earlier than the cycle after the result handshake.

## Configuration
- `SEQ_ALU_MUL_EN` defined:
  - `ctr`=4'b1011 is multiply-low (A×B mod 2^WIDTH) using an iterative shift-add, one bit per cycle, in a fourth state MUL.
  - Multiply latency is 1+WIDTH.
- `SEQ_ALU_MUL_EN` undefined: 4'b1011 behaves as pass B, latency 1, and no MUL state or multiplier logic exists.

## Structure
- Package `seq_alu_pkg` holds:
  - The `ctr[2:0]` operation constants (OP_ADD, OP_SLL, OP_SLT, OP_B, OP_XOR, OP_SR, OP_OR, OP_AND).
  - The `ctr` value for multiply, CTR_MUL = 4'b1011.
  - The state enum.
- Sub-module `seq_alu_shifter` holds the working register and remaining counter. It performs one SH_STEP-bounded left, logical-right or arithmetic-right step per cycle and signals when it is done.
- The top level holds the FSM, the single-cycle datapath and the output registers.

## Test plan
- Reset release, then add A=32'hFFFF_FFFF, B=1, `ctr`=0000 -> `out`=0, `zero`=1, `out_valid` 1 edge after acceptance.
- Signed compare, A=32'h8000_0000, B=1, `ctr`=0010 -> `out`=1, `less`=1. Same operands unsigned (`ctr`=1010) -> `out`=0, `less`=0.
- Arithmetic right shift, A=32'h8000_0000, B=31, `ctr`=1101, SH_STEP=1 -> `out`=32'hFFFF_FFFF after 32 edges; `in_ready`=0 throughout. Same op with SH_STEP=8 -> 5 edges.
- Shift left, A=1, B=0, `ctr`=0001 -> `out`=1 with latency 1. B=32'h0000_0025 (shamt 5) -> `out`=32.
- Back-pressure: hold `out_ready`=0 for 10 cycles with `in_valid`=1 -> result is stable, no new acceptance, and the next op is accepted the cycle after the handshake.
- `rst` pulsed during a SHIFT -> outputs return to reset values and the next operation completes correctly. With `SEQ_ALU_MUL_EN`: 7×9 -> 63 after 33 edges.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: operation codes, multiply ctr value, FSM state and shift-mode
// enums shared by the sequential ALU files.
// Optional feature macro: SEQ_ALU_MUL_EN adds the MUL state.
package seq_alu_pkg;

  // ctr[2:0] operation codes; ctr[3] selects the variant for ADD/SLT/SR
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SLT = 3'b010;
  localparam logic [2:0] OP_B   = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SR  = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_AND = 3'b111;

  // Full ctr value that selects multiply when the multiplier is built
  localparam logic [3:0] CTR_MUL = 4'b1011;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
`ifdef SEQ_ALU_MUL_EN
    DONE,
    MUL
`else
    DONE
`endif
  } state_e;

  typedef enum logic [1:0] {
    SH_LEFT,
    SH_LRIGHT,
    SH_ARIGHT
  } sh_mode_e;

endpackage

// File: rtl/seq_alu_if.sv
// seq_alu_if: operand/result handshake bundle between the decode stage
// (master) and the sequential ALU (slave).
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ctr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             less;

  modport master (
    output in_valid, A, B, ctr, out_ready,
    input  in_ready, out_valid, out, zero, less
  );

  modport slave (
    input  in_valid, A, B, ctr, out_ready,
    output in_ready, out_valid, out, zero, less
  );
endinterface

// File: rtl/seq_alu_shifter.sv
// seq_alu_shifter: iterative shifter. Holds the working register and the
// remaining shift count; each step moves by min(SH_STEP, remaining).
module seq_alu_shifter
  import seq_alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SH_STEP = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     step,
  input  sh_mode_e                 mode_in,
  input  logic [WIDTH-1:0]         data_in,
  input  logic [$clog2(WIDTH)-1:0] amount_in,
  output logic [WIDTH-1:0]         data_next,
  output logic                     last
);
  // One extra bit so SH_STEP == WIDTH is representable
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] STEP_MAX = CNT_W'(SH_STEP);

  logic [WIDTH-1:0] work_q, work_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] step_amt;
  sh_mode_e         mode_q, mode_d;

  // Step size, shifted value and next register contents
  always_comb begin
    step_amt = (rem_q < STEP_MAX) ? rem_q : STEP_MAX;
    case (mode_q)
      SH_LEFT:   data_next = work_q << step_amt;
      SH_LRIGHT: data_next = work_q >> step_amt;
      // working register starts as A, so its MSB is the latched A sign bit
      SH_ARIGHT: data_next = $signed(work_q) >>> step_amt;
      default:   data_next = work_q;
    endcase
    last   = (rem_q == step_amt);
    work_d = work_q;
    rem_d  = rem_q;
    mode_d = mode_q;
    if (load) begin
      work_d = data_in;
      rem_d  = {1'b0, amount_in};
      mode_d = mode_in;
    end else if (step) begin
      work_d = data_next;
      rem_d  = rem_q - step_amt;
    end
  end

  // Working register, remaining count and mode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_q <= '0;
      rem_q  <= '0;
      mode_q <= SH_LEFT;
    end else begin
      work_q <= work_d;
      rem_q  <= rem_d;
      mode_q <= mode_d;
    end
  end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with registered result/flags, iterative shifts and,
// with SEQ_ALU_MUL_EN defined, an iterative shift-add multiply-low.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SH_STEP = 1
) (
  input logic     clk,
  input logic     rst,
  seq_alu_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zero_q, zero_d;
  logic             less_q, less_d;

  logic [2:0]       op;
  logic [SHW-1:0]   shamt;
  logic             is_shift;
  sh_mode_e         sh_mode;
  logic [WIDTH-1:0] alu_res;
  logic             alu_less;
  logic             sh_load, sh_step, sh_last;
  logic [WIDTH-1:0] sh_next;

`ifdef SEQ_ALU_MUL_EN
  logic [WIDTH-1:0] mul_acc_q, mul_acc_d;
  logic [WIDTH-1:0] mul_mcand_q, mul_mcand_d;
  logic [WIDTH-1:0] mul_mplier_q, mul_mplier_d;
  logic [SHW-1:0]   mul_cnt_q, mul_cnt_d;
  logic [WIDTH-1:0] mul_sum;
`endif

  assign op       = bus.ctr[2:0];
  assign shamt    = bus.B[SHW-1:0];
  assign is_shift = (op == OP_SLL) || (op == OP_SR);
  assign sh_mode  = (op == OP_SLL) ? SH_LEFT : (bus.ctr[3] ? SH_ARIGHT : SH_LRIGHT);

  // Single-cycle datapath; shifts by zero simply pass A
  always_comb begin
    alu_res  = '0;
    alu_less = 1'b0;
    case (op)
      OP_ADD: alu_res = bus.ctr[3] ? (bus.A - bus.B) : (bus.A + bus.B);
      OP_SLT: begin
        if (bus.ctr[3]) alu_less = (bus.A < bus.B);
        else            alu_less = ($signed(bus.A) < $signed(bus.B));
        alu_res = {{(WIDTH-1){1'b0}}, alu_less};
      end
      OP_B:   alu_res = bus.B;
      OP_XOR: alu_res = bus.A ^ bus.B;
      OP_OR:  alu_res = bus.A | bus.B;
      OP_AND: alu_res = bus.A & bus.B;
      default: alu_res = bus.A;
    endcase
  end

  seq_alu_shifter #(
    .WIDTH   (WIDTH),
    .SH_STEP (SH_STEP)
  ) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (sh_load),
    .step      (sh_step),
    .mode_in   (sh_mode),
    .data_in   (bus.A),
    .amount_in (shamt),
    .data_next (sh_next),
    .last      (sh_last)
  );

  // FSM next state and output-register updates
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    zero_d  = zero_q;
    less_d  = less_q;
    sh_load = 1'b0;
    sh_step = 1'b0;
`ifdef SEQ_ALU_MUL_EN
    mul_acc_d    = mul_acc_q;
    mul_mcand_d  = mul_mcand_q;
    mul_mplier_d = mul_mplier_q;
    mul_cnt_d    = mul_cnt_q;
    mul_sum      = mul_acc_q + (mul_mplier_q[0] ? mul_mcand_q : '0);
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
`ifdef SEQ_ALU_MUL_EN
          if (bus.ctr == CTR_MUL) begin
            mul_acc_d    = '0;
            mul_mcand_d  = bus.A;
            mul_mplier_d = bus.B;
            mul_cnt_d    = '0;
            state_d      = MUL;
          end else
`endif
          if (is_shift && (shamt != '0)) begin
            sh_load = 1'b1;
            state_d = SHIFT;
          end else begin
            out_d   = alu_res;
            zero_d  = (alu_res == '0);
            less_d  = alu_less;
            state_d = DONE;
          end
        end
      end
      SHIFT: begin
        sh_step = 1'b1;
        if (sh_last) begin
          out_d   = sh_next;
          zero_d  = (sh_next == '0);
          less_d  = 1'b0;
          state_d = DONE;
        end
      end
`ifdef SEQ_ALU_MUL_EN
      MUL: begin
        mul_acc_d    = mul_sum;
        mul_mcand_d  = mul_mcand_q << 1;
        mul_mplier_d = mul_mplier_q >> 1;
        mul_cnt_d    = mul_cnt_q + 1'b1;
        if (mul_cnt_q == SHW'(WIDTH - 1)) begin
          out_d   = mul_sum;
          zero_d  = (mul_sum == '0);
          less_d  = 1'b0;
          state_d = DONE;
        end
      end
`endif
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      out_q   <= '0;
      zero_q  <= 1'b0;
      less_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
      less_q  <= less_d;
    end
  end

`ifdef SEQ_ALU_MUL_EN
  // Multiplier accumulator, shifted operands and bit counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_acc_q    <= '0;
      mul_mcand_q  <= '0;
      mul_mplier_q <= '0;
      mul_cnt_q    <= '0;
    end else begin
      mul_acc_q    <= mul_acc_d;
      mul_mcand_q  <= mul_mcand_d;
      mul_mplier_q <= mul_mplier_d;
      mul_cnt_q    <= mul_cnt_d;
    end
  end
`endif

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out       = out_q;
  assign bus.zero      = zero_q;
  assign bus.less      = less_q;
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: two seq_alu instances (SH_STEP 1 and 8) driven with identical
// stimulus; per-instance monitors score results against a reference model.
module tb_seq_alu;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] a_in      = '0;
  logic [W-1:0] b_in      = '0;
  logic [3:0]   ctr_in    = '0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  int issued   = 0;
  bit rnd_bp   = 1'b0;

  typedef struct {
    logic [W-1:0] res;
    logic         less;
    int           lat;
  } exp_t;

  logic [3:0]   stat   [2];
  logic [W-1:0] outv   [2];
  bit           busy_v [2];
  int           nacc_v [2];

  task automatic chk(input string name, input int idx, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s dut%0d actual=%h required=%h", name, idx, act, req);
    end
  endtask

  // Reference behaviour from the operation table
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [3:0] c, input int step);
    exp_t e;
    int sh;
    logic signed [W-1:0] sa;
    sh     = int'(b[4:0]);
    sa     = a;
    e.res  = '0;
    e.less = 1'b0;
    e.lat  = 1;
    case (c[2:0])
      3'd0: e.res = c[3] ? a - b : a + b;
      3'd1: e.res = a << sh;
      3'd2: begin
        if (c[3]) e.less = (a < b);
        else      e.less = (sa < $signed(b));
        e.res = W'(e.less);
      end
      3'd3: e.res = b;
      3'd4: e.res = a ^ b;
      3'd5: begin
        if (c[3]) e.res = sa >>> sh;
        else      e.res = a >> sh;
      end
      3'd6: e.res = a | b;
      default: e.res = a & b;
    endcase
    if ((c[2:0] == 3'd1 || c[2:0] == 3'd5) && sh > 0) e.lat = 1 + (sh + step - 1) / step;
`ifdef SEQ_ALU_MUL_EN
    if (c == 4'b1011) begin
      e.res  = a * b;
      e.less = 1'b0;
      e.lat  = 1 + W;
    end
`endif
    return e;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : gen_dut
    localparam int STEP = (gi == 0) ? 1 : 8;

    seq_alu_if #(.WIDTH(W)) bus ();
    assign bus.in_valid  = in_valid;
    assign bus.A         = a_in;
    assign bus.B         = b_in;
    assign bus.ctr       = ctr_in;
    assign bus.out_ready = out_ready;

    seq_alu #(.WIDTH(W), .SH_STEP(STEP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    exp_t         exp_q [$];
    exp_t         e;
    bit           busy = 1'b0, seen = 1'b0, rdy_bad = 1'b0, hold_bad = 1'b0;
    int           acc_cyc = 0, lat_meas = 0, n_acc = 0;
    logic [W-1:0] held_out;
    logic         held_z, held_l;

    assign stat[gi]   = {bus.in_ready, bus.out_valid, bus.zero, bus.less};
    assign outv[gi]   = bus.out;
    assign busy_v[gi] = busy;
    assign nacc_v[gi] = n_acc;

    // Monitor: push expected at acceptance, compare at result handshake
    always @(negedge clk) begin
      if (rst) begin
        exp_q.delete();
        busy = 1'b0;
        seen = 1'b0;
      end else if (busy) begin
        if (bus.in_ready) rdy_bad = 1'b1;
        if (bus.out_valid) begin
          if (!seen) begin
            seen     = 1'b1;
            lat_meas = cyc - acc_cyc;
            held_out = bus.out;
            held_z   = bus.zero;
            held_l   = bus.less;
          end else if (bus.out !== held_out || bus.zero !== held_z || bus.less !== held_l) begin
            hold_bad = 1'b1;
          end
          if (bus.out_ready) begin
            chk("queue_depth", gi, W'(exp_q.size()), 1);
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              chk("out", gi, bus.out, e.res);
              chk("zero", gi, W'(bus.zero), W'(e.res == '0));
              chk("less", gi, W'(bus.less), W'(e.less));
              chk("latency", gi, W'(lat_meas), W'(e.lat));
              chk("in_ready_low", gi, W'(rdy_bad), 0);
              chk("held_stable", gi, W'(hold_bad), 0);
              $display("txn dut%0d out=%h zero=%0d less=%0d lat=%0d", gi, bus.out, bus.zero, bus.less, lat_meas);
            end
            busy = 1'b0;
            seen = 1'b0;
          end
        end
      end else begin
        chk("idle_no_valid", gi, W'(bus.out_valid), 0);
        if (bus.in_valid && bus.in_ready) begin
          busy     = 1'b1;
          acc_cyc  = cyc;
          rdy_bad  = 1'b0;
          hold_bad = 1'b0;
          n_acc++;
          exp_q.push_back(model(bus.A, bus.B, bus.ctr, STEP));
        end
      end
    end
  end

  // Random back-pressure generator
  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic chk_reset();
    for (int i = 0; i < 2; i++) begin
      chk("rst_in_ready", i, W'(stat[i][3]), 1);
      chk("rst_out_valid", i, W'(stat[i][2]), 0);
      chk("rst_zero", i, W'(stat[i][1]), 0);
      chk("rst_less", i, W'(stat[i][0]), 0);
      chk("rst_out", i, outv[i], 0);
    end
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while ((busy_v[0] || busy_v[1]) && n < bound) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("wait_done_timeout", 0, W'(busy_v[0] | busy_v[1]), 0);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c);
    @(posedge clk);
    #1;
    a_in = a; b_in = b; ctr_in = c; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    issued++;
    wait_idle(600);
  endtask

  logic [W-1:0] dir_a [16] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                               32'h1, 32'h1, 32'h7, 32'h5, 32'h8000_0000, 32'h1234_5678,
                               32'h0F0F_0000, 32'hFF00_FF00, 32'hDEAD_BEEF, 32'h1,
                               32'hFFFF_FFFF, 32'h7FFF_FFFF};
  logic [W-1:0] dir_b [16] = '{32'h1, 32'h1, 32'h1, 32'd31, 32'h0, 32'h25, 32'h9, 32'h7,
                               32'h4, 32'hF0F0_F0F0, 32'h00F0_F00F, 32'h0F0F_0F0F,
                               32'hCAFE_F00D, 32'h8000_0000, 32'h3F, 32'h1};
  logic [3:0]   dir_c [16] = '{4'h0, 4'h2, 4'hA, 4'hD, 4'h1, 4'h1, 4'hB, 4'h8,
                               4'h5, 4'h4, 4'h6, 4'h7, 4'h3, 4'h2, 4'h5, 4'h0};

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset();
    rst = 1'b0;

    for (int i = 0; i < 16; i++) issue(dir_a[i], dir_b[i], dir_c[i]);

    // Back-pressure: result held, in_valid ignored, next accept right after handshake
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    a_in = 32'hA5A5_0000; b_in = 32'h0000_5A5A; ctr_in = 4'h4; in_valid = 1'b1;
    @(posedge clk);
    #1;
    a_in = 32'h1200_0034; b_in = 32'h0056_0000; ctr_in = 4'h6;
    repeat (10) @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("bp_idle_in_ready", i, W'(stat[i][3]), 1);
      chk("bp_idle_out_valid", i, W'(stat[i][2]), 0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("bp_next_accepted", i, W'(stat[i][3]), 0);
      chk("bp_next_valid", i, W'(stat[i][2]), 1);
    end
    issued += 2;
    wait_idle(600);

    // Reset pulsed mid-shift aborts the operation
    @(posedge clk);
    #1;
    a_in = 32'h0000_0003; b_in = 32'd30; ctr_in = 4'h1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    issued++;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_reset();
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(32'h8000_0001, 32'd3, 4'hD);

    // Randomized operations with random back-pressure
    rnd_bp = 1'b1;
    for (int i = 0; i < 150; i++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom;
      rb = ($urandom_range(0, 1) != 0) ? W'($urandom_range(0, 40)) : W'($urandom);
      issue(ra, rb, 4'($urandom_range(0, 15)));
    end
    rnd_bp = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    for (int i = 0; i < 2; i++) chk("accept_count", i, W'(nacc_v[i]), W'(issued));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
